// File: rtl/wb_bridge_pkg.sv
// ----------------------------------------------------------------------------
// wb_bridge_pkg
//   Shared definitions for the Wishbone timeout bridge.
//   - state_t / IDLE / REQ / RESP : bridge FSM encoding
//   - cnt_width()                 : width of a counter that must hold 0..timeout
// ----------------------------------------------------------------------------
package wb_bridge_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t RESP = 2'd2;

    // A disabled timer (timeout == 0) still gets a 1-bit counter so that
    // the counter declaration never collapses to zero width.
    function automatic int cnt_width(input int timeout);
        if (timeout <= 0) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_if.sv
// ----------------------------------------------------------------------------
// wb_if
//   Classic Wishbone bus bundle (single cycle CYC/STB handshake).
//   Ports of the bundle:
//     adr, dat_w, cyc, stb, we, sel : driven by the master
//     dat_r, ack, err                : driven by the slave
//   Modports:
//     master : side that issues requests
//     slave  : side that answers requests
// ----------------------------------------------------------------------------
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    ack;
    logic                    err;

    modport master (
        output adr, dat_w, cyc, stb, we, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, cyc, stb, we, sel,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_bus_timer.sv
// ----------------------------------------------------------------------------
// wb_bus_timer
//   Saturating cycle counter guarding one outstanding bus request.
//   Ports:
//     clk      in  clock, rising edge
//     rstn     in  asynchronous active-low reset
//     clear    in  force the count back to zero
//     enable   in  count one cycle of waiting
//     expired  out high during the TIMEOUT-th enabled cycle after a clear
//   TIMEOUT == 0 disables the timer: expired is never asserted.
// ----------------------------------------------------------------------------
module wb_bus_timer
    import wb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Holds at CNT_MAX instead of wrapping, so a stuck enable can never
    // re-arm the expiry a second time.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = enable && (count_reg == CNT_LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_timeout_bridge.sv
// ----------------------------------------------------------------------------
// wb_timeout_bridge
//   Single-outstanding Wishbone bridge. Each upstream request is registered,
//   forwarded downstream and guarded by a bus timer. A silent target gets an
//   ERR returned upstream and its address latched for diagnosis.
//   Ports:
//     clk           in  clock, rising edge
//     rstn          in  asynchronous active-low reset
//     s             wb_if.slave   upstream port (from subsystem master)
//     m             wb_if.master  downstream port (to system bus)
//     timeout_clr   in  one-cycle pulse clearing timeout_irq
//     timeout_irq   out sticky flag, set on every timeout
//     timeout_addr  out address of the most recent timed-out request
// ----------------------------------------------------------------------------
module wb_timeout_bridge
    import wb_bridge_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int TIMEOUT       = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    wb_if.slave                      s,
    wb_if.master                     m,
    input  logic                     timeout_clr,
    output logic                     timeout_irq,
    output logic [WB_ADDR_WIDTH-1:0] timeout_addr
);

    localparam int SEL_WIDTH = WB_DATA_WIDTH / 8;

    state_t                   state_reg;
    state_t                   state_next;

    logic [WB_ADDR_WIDTH-1:0] req_adr_reg;
    logic [WB_DATA_WIDTH-1:0] req_dat_reg;
    logic [SEL_WIDTH-1:0]     req_sel_reg;
    logic                     req_we_reg;

    logic                     err_reg;
    logic                     abandon_reg;
    logic [WB_DATA_WIDTH-1:0] rdata_reg;

    logic                     irq_reg;
    logic [WB_ADDR_WIDTH-1:0] taddr_reg;

    logic                     in_idle;
    logic                     in_req;
    logic                     in_resp;
    logic                     s_req;
    logic                     expired;
    logic                     timeout_hit;

    assign in_idle = (state_reg == IDLE);
    assign in_req  = (state_reg == REQ);
    assign in_resp = (state_reg == RESP);
    assign s_req   = s.cyc && s.stb;

    // A reply arriving in the very cycle the timer expires takes priority.
    assign timeout_hit = in_req && expired && !m.ack && !m.err;

    wb_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (!in_req),
        .enable  (in_req),
        .expired (expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (s_req) state_next = REQ;
            REQ:     if (m.ack || m.err || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            req_adr_reg <= '0;
            req_dat_reg <= '0;
            req_sel_reg <= '0;
            req_we_reg  <= 1'b0;
            err_reg     <= 1'b0;
            abandon_reg <= 1'b0;
            rdata_reg   <= '0;
            irq_reg     <= 1'b0;
            taddr_reg   <= '0;
        end else begin
            state_reg <= state_next;

            if (in_idle && s_req) begin
                req_adr_reg <= s.adr;
                req_dat_reg <= s.dat_w;
                req_sel_reg <= s.sel;
                req_we_reg  <= s.we;
                abandon_reg <= 1'b0;
            end

            if (in_req) begin
                // Upstream gave up: keep the downstream transfer legal to the
                // end, but swallow the response.
                if (!s_req) begin
                    abandon_reg <= 1'b1;
                end
                if (m.err) begin
                    err_reg   <= 1'b1;
                    rdata_reg <= '0;
                end else if (m.ack) begin
                    err_reg   <= 1'b0;
                    rdata_reg <= req_we_reg ? '0 : m.dat_r;
                end else if (timeout_hit) begin
                    err_reg   <= 1'b1;
                    rdata_reg <= '0;
                end
            end

            // Set dominates clear so a coincident clear cannot lose a timeout.
            if (timeout_hit) begin
                irq_reg   <= 1'b1;
                taddr_reg <= req_adr_reg;
            end else if (timeout_clr) begin
                irq_reg <= 1'b0;
            end
        end
    end

    // Downstream request is decoded from registers only: no s -> m comb path.
    assign m.cyc   = in_req;
    assign m.stb   = in_req;
    assign m.we    = in_req && req_we_reg;
    assign m.adr   = req_adr_reg;
    assign m.dat_w = req_dat_reg;
    assign m.sel   = req_sel_reg;

    assign s.ack   = in_resp && !err_reg && !abandon_reg;
    assign s.err   = in_resp &&  err_reg && !abandon_reg;
    assign s.dat_r = (in_resp && !abandon_reg) ? rdata_reg : '0;

    assign timeout_irq  = irq_reg;
    assign timeout_addr = taddr_reg;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// ----------------------------------------------------------------------------
// tb_wb_timeout_bridge
//   Directed bench for wb_timeout_bridge (TIMEOUT = 16). A small target model
//   answers downstream requests after a configurable number of REQ cycles;
//   expected upstream responses are queued when a request is issued and
//   compared when the bridge answers.
// ----------------------------------------------------------------------------
module tb_wb_timeout_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        logic          ack;
        logic          err;
        logic [DW-1:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          timeout_clr;
    logic          timeout_irq;
    logic [AW-1:0] timeout_addr;

    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();
    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();

    wb_timeout_bridge #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .TIMEOUT       (TO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s            (s_bus),
        .m            (m_bus),
        .timeout_clr  (timeout_clr),
        .timeout_irq  (timeout_irq),
        .timeout_addr (timeout_addr)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Target model configuration (written by the main sequence only).
    int            tgt_delay;   // REQ cycle on which to reply, 0 = never
    int            tgt_kind;    // 0 = ACK, 1 = ERR, 2 = ACK+ERR
    logic [DW-1:0] tgt_rdata;
    logic          inject_ack;  // stray ACK, independent of any request

    // Target model observations (written by the target model only).
    int            req_cyc = 0;
    int            cyc_len = 0;
    logic [AW-1:0] seen_adr;
    logic [DW-1:0] seen_dat;
    logic [3:0]    seen_sel;
    logic          seen_we;
    logic          fire;

    initial begin
        m_bus.ack   = 1'b0;
        m_bus.err   = 1'b0;
        m_bus.dat_r = '0;
        forever begin
            @(negedge clk);
            if (m_bus.cyc && m_bus.stb) begin
                req_cyc = req_cyc + 1;
                if (req_cyc == 1) begin
                    seen_adr = m_bus.adr;
                    seen_dat = m_bus.dat_w;
                    seen_sel = m_bus.sel;
                    seen_we  = m_bus.we;
                end
            end else begin
                if (req_cyc != 0) cyc_len = req_cyc;
                req_cyc = 0;
            end
            fire        = m_bus.cyc && m_bus.stb && (tgt_delay != 0) && (req_cyc == tgt_delay);
            m_bus.ack   = (fire && tgt_kind != 1) || inject_ack;
            m_bus.err   = fire && tgt_kind != 0;
            m_bus.dat_r = fire ? tgt_rdata : '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic we,
                             input bit expect_resp, input logic exp_err, input logic [DW-1:0] exp_dat);
        exp_t e;
        if (expect_resp) begin
            e.ack = !exp_err;
            e.err = exp_err;
            e.dat = exp_dat;
            exp_q.push_back(e);
        end
        s_bus.adr   = adr;
        s_bus.dat_w = dat;
        s_bus.we    = we;
        s_bus.sel   = 4'hF;
        s_bus.cyc   = 1'b1;
        s_bus.stb   = 1'b1;
    endtask

    // Waits (bounded) for ACK/ERR, scores it, releases the request and checks
    // the response is a single-cycle pulse. lat counts the STB cycle as 1.
    task automatic wait_resp(input string tag, input int clr_at, output int lat);
        int   n   = 0;
        bit   got = 0;
        exp_t e;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            timeout_clr = (n == clr_at);
            if (s_bus.ack || s_bus.err) got = 1;
        end
        timeout_clr = 1'b0;
        check({tag, "_seen"}, 32'(got), 32'd1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_ack"}, 32'(s_bus.ack), 32'(e.ack));
            check({tag, "_err"}, 32'(s_bus.err), 32'(e.err));
            check({tag, "_dat_r"}, s_bus.dat_r, e.dat);
        end
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        s_bus.we  = 1'b0;
        lat = n + 1;
        @(negedge clk);
        check({tag, "_one_cycle"}, 32'({s_bus.ack, s_bus.err}), 32'd0);
    endtask

    initial begin
        int lat;
        int cnt;

        rstn        = 1'b0;
        timeout_clr = 1'b0;
        s_bus.adr   = '0;
        s_bus.dat_w = '0;
        s_bus.we    = 1'b0;
        s_bus.sel   = '0;
        s_bus.cyc   = 1'b0;
        s_bus.stb   = 1'b0;
        tgt_delay   = 0;
        tgt_kind    = 0;
        tgt_rdata   = '0;
        inject_ack  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_m_cyc",   32'(m_bus.cyc), 32'd0);
        check("rst_m_adr",   m_bus.adr, 32'd0);
        check("rst_s_resp",  32'({s_bus.ack, s_bus.err}), 32'd0);
        check("rst_s_dat_r", s_bus.dat_r, 32'd0);
        check("rst_irq",     32'(timeout_irq), 32'd0);
        check("rst_taddr",   timeout_addr, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Write, target acks on the 2nd REQ cycle.
        tgt_delay = 2; tgt_kind = 0;
        start_req(32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0);
        wait_resp("t1", 0, lat);
        check("t1_latency", lat, 32'd4);
        check("t1_m_adr",   seen_adr, 32'h100);
        check("t1_m_dat",   seen_dat, 32'hDEADBEEF);
        check("t1_m_sel",   32'(seen_sel), 32'hF);
        check("t1_m_we",    32'(seen_we), 32'd1);
        check("t1_irq",     32'(timeout_irq), 32'd0);

        // Read, target acks on the 1st REQ cycle (minimum latency).
        tgt_delay = 1; tgt_rdata = 32'h12345678;
        start_req(32'h2000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678);
        wait_resp("t2", 0, lat);
        check("t2_latency", lat, 32'd3);
        check("t2_m_we",    32'(seen_we), 32'd0);

        // Silent target: timeout after 16 REQ cycles.
        tgt_delay = 0;
        start_req(32'hFFF0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        wait_resp("t3", 0, lat);
        check("t3_latency", lat, 32'd18);
        check("t3_cyc_len", cyc_len, 32'd16);
        check("t3_irq",     32'(timeout_irq), 32'd1);
        check("t3_taddr",   timeout_addr, 32'hFFF0);
        repeat (4) @(negedge clk);
        inject_ack = 1'b1;
        repeat (2) @(negedge clk);
        inject_ack = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_bus.ack || s_bus.err || m_bus.cyc) cnt++;
        end
        check("t3_late_ack_ignored", cnt, 32'd0);
        check("t3_irq_kept",         32'(timeout_irq), 32'd1);

        // Clear the sticky flag.
        timeout_clr = 1'b1;
        @(negedge clk);
        timeout_clr = 1'b0;
        check("t5_irq_cleared", 32'(timeout_irq), 32'd0);

        // Reply on the 16th REQ cycle beats the timeout.
        tgt_delay = 16; tgt_kind = 0; tgt_rdata = 32'hCAFEF00D;
        start_req(32'h3000, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
        wait_resp("t4", 0, lat);
        check("t4_latency", lat, 32'd18);
        check("t4_irq",     32'(timeout_irq), 32'd0);

        // ACK and ERR together: ERR wins.
        tgt_delay = 3; tgt_kind = 2; tgt_rdata = 32'h55AA55AA;
        start_req(32'h3004, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        wait_resp("t4b", 0, lat);
        check("t4b_irq", 32'(timeout_irq), 32'd0);

        // Clear pulse coincident with a new timeout: flag stays set.
        tgt_delay = 0; tgt_kind = 0;
        start_req(32'h0ABC, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        wait_resp("t5b", 16, lat);
        check("t5b_irq",   32'(timeout_irq), 32'd1);
        check("t5b_taddr", timeout_addr, 32'h0ABC);

        // Upstream drops STB mid-transfer: downstream completes, no response.
        tgt_delay = 3; tgt_kind = 0;
        start_req(32'h7000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (s_bus.ack || s_bus.err) cnt++;
        end
        check("ab_no_resp", cnt, 32'd0);
        check("ab_cyc_len", cyc_len, 32'd3);

        // Reset in the middle of REQ.
        tgt_delay = 0;
        start_req(32'h4000, 32'h11112222, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        check("t6_pre_cyc", 32'(m_bus.cyc), 32'd1);
        rstn      = 1'b0;
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        s_bus.we  = 1'b0;
        #1;
        check("t6_m_cyc",   32'(m_bus.cyc), 32'd0);
        check("t6_m_stb",   32'(m_bus.stb), 32'd0);
        check("t6_m_adr",   m_bus.adr, 32'd0);
        check("t6_s_resp",  32'({s_bus.ack, s_bus.err}), 32'd0);
        check("t6_irq",     32'(timeout_irq), 32'd0);
        check("t6_taddr",   timeout_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        tgt_delay = 2; tgt_rdata = 32'h5A5A0F0F;
        start_req(32'h5000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5A5A0F0F);
        wait_resp("t6_after", 0, lat);
        check("t6_after_latency", lat, 32'd4);

        check("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
